round_ctl: RTL and testbench

Game-flow controller that consumes the `hit`, `miss` and `shot_fired` pulses produced by the trigger/input stage and turns them into duck lifecycle, ammo, per-round hit tally, score and game-over status for the renderer and HUD. It sits directly downstream of the trigger stage and upstream of the duck sprite engine and score display. All game timing is counted in `new_frame` pulses.

---
 rtl/round_ctl.sv | 169 ++++++++++++++++
 tb/tb_round_ctl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_ctl.sv
// Game-flow controller: duck lifecycle, ammo, per-round hit tally, score and
// game-over status, with all game timing counted in new_frame pulses.
module round_ctl #(
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int HITS_TO_PASS    = 6,
    parameter int ESCAPE_FRAMES   = 300,
    parameter int ANIM_FRAMES     = 60,
    parameter int POINTS_PER_HIT  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        start,
    input  logic        shot_fired,
    input  logic        hit,
    input  logic        miss,
    output logic [2:0]  state,
    output logic        duck_spawn,
    output logic        duck_active,
    output logic        duck_fall,
    output logic        duck_flee,
    output logic [1:0]  shots_left,
    output logic [3:0]  duck_index,
    output logic [3:0]  ducks_hit,
    output logic [6:0]  round_num,
    output logic [13:0] score,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_ACTIVE    = 3'd2,
        S_FALL      = 3'd3,
        S_FLEE      = 3'd4,
        S_ROUND_END = 3'd5,
        S_GAME_OVER = 3'd6
    } state_e;

    localparam logic [9:0]  ESC_LAST   = 10'(ESCAPE_FRAMES - 1);
    localparam logic [9:0]  ANIM_LAST  = 10'(ANIM_FRAMES - 1);
    localparam logic [3:0]  LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
    localparam logic [3:0]  PASS_HITS  = 4'(HITS_TO_PASS);
    localparam logic [1:0]  SHOTS_INIT = 2'(SHOTS_PER_DUCK);
    localparam logic [14:0] SCORE_MAX  = 15'd9999;

    state_e      state_q;
    logic        spawn_q, active_q, fall_q, flee_q, game_over_q;
    logic [1:0]  shots_q;
    logic [3:0]  duck_index_q, ducks_hit_q;
    logic [6:0]  round_q;
    logic [13:0] score_q;
    logic [9:0]  fcnt_q;

    // One extra bit so the saturation check sees the carry past 9999.
    logic [14:0] score_sum;
    logic [13:0] score_d;
    logic        escape, anim_done;

    assign score_sum = {1'b0, score_q} + 15'(POINTS_PER_HIT);
    assign score_d   = (score_sum > SCORE_MAX) ? 14'(SCORE_MAX) : score_sum[13:0];
    assign escape    = new_frame && (fcnt_q == ESC_LAST);
    assign anim_done = new_frame && (fcnt_q == ANIM_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            spawn_q      <= 1'b0;
            active_q     <= 1'b0;
            fall_q       <= 1'b0;
            flee_q       <= 1'b0;
            game_over_q  <= 1'b0;
            shots_q      <= '0;
            duck_index_q <= '0;
            ducks_hit_q  <= '0;
            round_q      <= '0;
            score_q      <= '0;
            fcnt_q       <= '0;
        end else begin
            spawn_q <= 1'b0;
            fall_q  <= 1'b0;
            flee_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        score_q      <= '0;
                        ducks_hit_q  <= '0;
                        duck_index_q <= '0;
                        round_q      <= 7'd1;
                        game_over_q  <= 1'b0;
                        fcnt_q       <= '0;
                        state_q      <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    shots_q  <= SHOTS_INIT;
                    fcnt_q   <= '0;
                    state_q  <= S_ACTIVE;
                    spawn_q  <= 1'b1;
                    active_q <= 1'b1;
                end
                S_ACTIVE: begin
                    if (shot_fired && shots_q != 2'd0)
                        shots_q <= shots_q - 2'd1;
                    if (new_frame)
                        fcnt_q <= fcnt_q + 10'd1;
                    // A hit wins over a same-cycle miss or timeout.
                    if (hit) begin
                        ducks_hit_q <= ducks_hit_q + 4'd1;
                        score_q     <= score_d;
                        fcnt_q      <= '0;
                        active_q    <= 1'b0;
                        fall_q      <= 1'b1;
                        state_q     <= S_FALL;
                    end else if ((miss && shots_q == 2'd0) || escape) begin
                        fcnt_q   <= '0;
                        active_q <= 1'b0;
                        flee_q   <= 1'b1;
                        state_q  <= S_FLEE;
                    end
                end
                S_FALL, S_FLEE: begin
                    if (anim_done) begin
                        fcnt_q <= '0;
                        if (duck_index_q < LAST_DUCK) begin
                            duck_index_q <= duck_index_q + 4'd1;
                            state_q      <= S_SPAWN;
                        end else begin
                            state_q <= S_ROUND_END;
                        end
                    end else if (new_frame) begin
                        fcnt_q <= fcnt_q + 10'd1;
                    end
                end
                S_ROUND_END: begin
                    if (anim_done) begin
                        fcnt_q <= '0;
                        if (ducks_hit_q >= PASS_HITS) begin
                            round_q      <= (round_q == 7'd99) ? 7'd99 : round_q + 7'd1;
                            duck_index_q <= '0;
                            ducks_hit_q  <= '0;
                            state_q      <= S_SPAWN;
                        end else begin
                            game_over_q <= 1'b1;
                            state_q     <= S_GAME_OVER;
                        end
                    end else if (new_frame) begin
                        fcnt_q <= fcnt_q + 10'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state       = state_q;
    assign duck_spawn  = spawn_q;
    assign duck_active = active_q;
    assign duck_fall   = fall_q;
    assign duck_flee   = flee_q;
    assign shots_left  = shots_q;
    assign duck_index  = duck_index_q;
    assign ducks_hit   = ducks_hit_q;
    assign round_num   = round_q;
    assign score       = score_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_round_ctl.sv
// Bench for round_ctl: directed game scenarios followed by random play, every
// cycle compared against a rule-level game model.
module tb_round_ctl;

    localparam int SHOTS = 3, DUCKS = 10, HITS = 6, ESC = 300, ANIM = 60, PTS = 100;
    localparam int IDLE = 0, SPAWN = 1, ACTIVE = 2, FALL = 3, FLEE = 4, RND_END = 5, GOVER = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1, new_frame = 1'b0, start = 1'b0;
    logic        shot_fired = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [2:0]  state;
    logic        duck_spawn, duck_active, duck_fall, duck_flee, game_over;
    logic [1:0]  shots_left;
    logic [3:0]  duck_index, ducks_hit;
    logic [6:0]  round_num;
    logic [13:0] score;

    int n_chk = 0, n_fail = 0;

    // Reference game state, in plain integers.
    int m_st = IDLE, m_shots = 0, m_idx = 0, m_dh = 0, m_round = 0, m_score = 0, m_fc = 0;
    bit m_spawn = 0, m_fall = 0, m_flee = 0;

    round_ctl dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .start(start),
        .shot_fired(shot_fired), .hit(hit), .miss(miss),
        .state(state), .duck_spawn(duck_spawn), .duck_active(duck_active),
        .duck_fall(duck_fall), .duck_flee(duck_flee), .shots_left(shots_left),
        .duck_index(duck_index), .ducks_hit(ducks_hit), .round_num(round_num),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, s, nf, sh, h, m);
        int prev_shots;
        bit tmo;
        m_spawn = 0; m_fall = 0; m_flee = 0;
        if (r) begin
            m_st = IDLE; m_shots = 0; m_idx = 0; m_dh = 0; m_round = 0; m_score = 0; m_fc = 0;
            return;
        end
        case (m_st)
            IDLE, GOVER: if (s) begin
                m_score = 0; m_dh = 0; m_idx = 0; m_round = 1; m_fc = 0; m_st = SPAWN;
            end
            SPAWN: begin
                m_shots = SHOTS; m_fc = 0; m_st = ACTIVE; m_spawn = 1;
            end
            ACTIVE: begin
                prev_shots = m_shots;
                if (sh && m_shots > 0) m_shots--;
                if (nf) m_fc++;
                tmo = nf && (m_fc == ESC);
                if (h) begin
                    m_dh++;
                    m_score = (m_score + PTS > 9999) ? 9999 : m_score + PTS;
                    m_fc = 0; m_st = FALL; m_fall = 1;
                end else if ((m && prev_shots == 0) || tmo) begin
                    m_fc = 0; m_st = FLEE; m_flee = 1;
                end
            end
            FALL, FLEE, RND_END: if (nf) begin
                m_fc++;
                if (m_fc == ANIM) begin
                    m_fc = 0;
                    if (m_st == RND_END) begin
                        if (m_dh >= HITS) begin
                            m_round = (m_round >= 99) ? 99 : m_round + 1;
                            m_idx = 0; m_dh = 0; m_st = SPAWN;
                        end else begin
                            m_st = GOVER;
                        end
                    end else if (m_idx < DUCKS - 1) begin
                        m_idx++; m_st = SPAWN;
                    end else begin
                        m_st = RND_END;
                    end
                end
            end
            default: m_st = IDLE;
        endcase
    endtask

    task automatic check_all();
        chk("state", state, m_st);
        chk("duck_spawn", duck_spawn, m_spawn);
        chk("duck_active", duck_active, (m_st == ACTIVE));
        chk("duck_fall", duck_fall, m_fall);
        chk("duck_flee", duck_flee, m_flee);
        chk("shots_left", shots_left, m_shots);
        chk("duck_index", duck_index, m_idx);
        chk("ducks_hit", ducks_hit, m_dh);
        chk("round_num", round_num, m_round);
        chk("score", score, m_score);
        chk("game_over", game_over, (m_st == GOVER));
    endtask

    task automatic cyc(input bit r, s, nf, sh, h, m);
        rst = r; start = s; new_frame = nf; shot_fired = sh; hit = h; miss = m;
        model_step(r, s, nf, sh, h, m);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Run frames until no hold state remains, bounded.
    task automatic drain();
        int n = 0;
        while ((m_st == FALL || m_st == FLEE || m_st == RND_END) && n < 300) begin
            cyc(0, 0, 1, 0, 0, 0);
            n++;
        end
        chk("drain_bound", (n < 300), 1);
    endtask

    task automatic play_duck(input bit do_hit);
        int n = 0;
        drain();
        while (m_st != ACTIVE && n < 4) begin
            cyc(0, 0, 0, 0, 0, 0);
            n++;
        end
        chk("reach_active", state, ACTIVE);
        if (do_hit) begin
            cyc(0, 0, 0, 0, 1, 0);
        end else begin
            repeat (SHOTS) cyc(0, 0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0, 1);
        end
    endtask

    initial begin
        // Reset values
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_state", state, IDLE);
        chk("rst_score", score, 0);
        chk("rst_round", round_num, 0);
        chk("rst_shots", shots_left, 0);

        // Start: SPAWN at +1, ACTIVE with spawn pulse at +2
        cyc(0, 1, 0, 0, 0, 0);
        chk("start_spawn", state, SPAWN);
        cyc(0, 0, 0, 0, 0, 0);
        chk("first_active", state, ACTIVE);
        chk("first_spawn_pulse", duck_spawn, 1);
        chk("first_shots", shots_left, 3);
        chk("first_round", round_num, 1);

        // Shot, then hit 10 frames later
        cyc(0, 0, 0, 1, 0, 0);
        chk("shot_dec", shots_left, 2);
        repeat (10) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("hit_fall", state, FALL);
        chk("hit_fall_pulse", duck_fall, 1);
        chk("hit_count", ducks_hit, 1);
        chk("hit_score", score, 100);
        repeat (ANIM) cyc(0, 0, 1, 0, 0, 0);
        chk("fall_to_spawn", state, SPAWN);
        chk("fall_idx", duck_index, 1);

        // Interleaved shots and misses; 4th shot at zero ammo
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("no_underflow", shots_left, 0);
        chk("still_active", state, ACTIVE);
        cyc(0, 0, 0, 0, 0, 1);
        chk("third_miss_flee", state, FLEE);
        cyc(0, 0, 0, 0, 1, 0);
        chk("late_hit_score", score, 100);
        drain();

        // Timeout on the 300th frame
        cyc(0, 0, 0, 0, 0, 0);
        repeat (ESC - 1) cyc(0, 0, 1, 0, 0, 0);
        chk("pre_timeout", state, ACTIVE);
        cyc(0, 0, 1, 0, 0, 0);
        chk("timeout_flee", state, FLEE);
        drain();

        // Hit with the 300th frame wins
        cyc(0, 0, 0, 0, 0, 0);
        repeat (ESC - 1) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("hit_beats_timeout", state, FALL);

        // Finish round 1 with 6 hits in total
        repeat (4) play_duck(1);
        repeat (2) play_duck(0);
        while (m_st == FALL || m_st == FLEE) cyc(0, 0, 1, 0, 0, 0);
        chk("round_end", state, RND_END);
        drain();
        chk("round2_num", round_num, 2);
        chk("round2_hits", ducks_hit, 0);

        // Round 2 with 5 hits ends the game
        repeat (5) play_duck(1);
        repeat (5) play_duck(0);
        drain();
        chk("game_over_state", state, GOVER);
        chk("game_over_flag", game_over, 1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("restart_score", score, 0);
        chk("restart_round", round_num, 1);

        // Score saturation
        repeat (99) play_duck(1);
        chk("score_9900", score, 9900);
        repeat (2) play_duck(1);
        chk("score_sat", score, 9999);

        // Reset during FALL
        chk("in_fall", state, FALL);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_fall_state", state, IDLE);
        chk("rst_fall_score", score, 0);
        chk("rst_fall_go", game_over, 0);

        // Random play
        for (int i = 0; i < 20000; i++) begin
            cyc($urandom_range(0, 2999) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
